// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath.
// Holds M (multiplicand), A (WIDTH+1 accumulator), Q (multiplier), Q_-1 and
// the iteration counter, and executes the control word issued by the Booth
// control unit every clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides all control bits
//   inbus        operand bus, loaded into M on c0 and into Q on c1
//   control      {c7..c0}; c7 reserved
//   q_reg        {Q[0], Q_-1} for the controller's add/sub/nop decision
//   counter_out  iteration counter
//   outbus       registered result word (c5: Q, c6: A low bits)
//   out_valid    one-cycle pulse when outbus carries a new word
module booth_datapath #(
  parameter int WIDTH        = 8,
  parameter int COUNTER_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        inbus,
  input  logic [7:0]              control,
  output logic [1:0]              q_reg,
  output logic [COUNTER_BITS-1:0] counter_out,
  output logic [WIDTH-1:0]        outbus,
  output logic                    out_valid
);

  logic [WIDTH-1:0]        m;
  logic [WIDTH:0]          a;
  logic [WIDTH-1:0]        q;
  logic                    qm1;
  logic [COUNTER_BITS-1:0] cnt;

  logic [WIDTH:0]          a_arith;
  logic [WIDTH:0]          a_next;
  logic [WIDTH-1:0]        q_next;
  logic                    qm1_next;
  logic [COUNTER_BITS-1:0] cnt_next;
  logic                    ctrl_unused;

  assign ctrl_unused = control[7];

  // M is sign-extended so that -2^(WIDTH-1) can be negated without overflow
  // inside the WIDTH+1 bit accumulator.
  logic [WIDTH:0] m_ext;
  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    a_arith = a;
    if (control[2])
      a_arith = control[3] ? (a - m_ext) : (a + m_ext);
  end

  // Shift operates on the post-add/sub accumulator so c2|c4 completes one
  // full Booth iteration in a single cycle. c1 (fresh load) dominates.
  always_comb begin
    a_next   = a;
    q_next   = q;
    qm1_next = qm1;
    cnt_next = cnt;
    if (control[1]) begin
      a_next   = '0;
      q_next   = inbus;
      qm1_next = 1'b0;
      cnt_next = '0;
    end else begin
      a_next = a_arith;
      if (control[4]) begin
        a_next   = {a_arith[WIDTH], a_arith[WIDTH:1]};
        q_next   = {a_arith[0], q[WIDTH-1:1]};
        qm1_next = q[0];
        cnt_next = cnt + COUNTER_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m         <= '0;
      a         <= '0;
      q         <= '0;
      qm1       <= 1'b0;
      cnt       <= '0;
      outbus    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (control[0]) m <= inbus;
      a   <= a_next;
      q   <= q_next;
      qm1 <= qm1_next;
      cnt <= cnt_next;
      // Output words use pre-edge register values; c5 has priority.
      if (control[5]) begin
        outbus    <= q;
        out_valid <= 1'b1;
      end else if (control[6]) begin
        outbus    <= a[WIDTH-1:0];
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign q_reg       = {q[0], qm1};
  assign counter_out = cnt;

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
- Radix-2 Booth multiplier datapath. It sits directly downstream of the Booth control unit and executes its one-hot control word.
- Holds the multiplicand M, the accumulator A, the multiplier Q, the Booth bit Q_-1 and the iteration counter.
- Returns q_reg and counter_out to the control unit so it can pick its next state.
- Drives the product onto a shared output bus, low half and high half in separate steps.

Parameters:
- WIDTH, 8, operand width in bits, two's complement; product is 2*WIDTH bits.
- COUNTER_BITS, 3, iteration counter width; control unit compares counter_out against its MAX_VALUE_COUNT.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inbus  input  WIDTH  operand input bus, sampled on c0/c1 cycles.
- control  input  8  one-hot-ish control word {c7..c0} from control unit; c7 reserved, ignored.
- q_reg  output  2  {Q[0], Q_-1}, combinational from registers.
- counter_out  output  COUNTER_BITS  iteration counter, combinational from register.
- outbus  output  WIDTH  registered result bus.
- out_valid  output  1  registered, high for one cycle when outbus carries a new word.

Behaviour:
- Reset (rst=1 at edge):
  - A, Q, Q_-1, M, counter, outbus and out_valid all go to 0.
  - rst overrides every control bit, including mid-multiplication; the multiplication is lost.
- A is held internally as WIDTH+1 bits. M is sign-extended to WIDTH+1 for add/sub, so M = -2^(WIDTH-1) multiplies correctly.
- c0: M <= inbus.
- c1: Q <= inbus; A <= 0; Q_-1 <= 0; counter <= 0.
- c0 and c1 may be asserted together; both loads take effect.
- c2: A <= A + M when c3=0, A <= A - M when c3=1. Arithmetic is modulo 2^(WIDTH+1); carry is discarded.
- c3 without c2 has no effect.
- c4:
  - Arithmetic right shift of {A, Q, Q_-1} by one: A MSB replicated, A[0]->Q[WIDTH-1], Q[0]->Q_-1.
  - counter <= counter + 1, wrapping to 0 at 2^COUNTER_BITS.
- c2 and c4 in the same cycle: the shift operates on the post-add/sub A value. Single-cycle result, no hazard.
- c1 with c2 or c4 in the same cycle: c1 wins; the other bits are ignored for A, Q, Q_-1 and counter.
- c5: next edge outbus <= Q (product low half), out_valid <= 1.
- c6: next edge outbus <= A[WIDTH-1:0] (product high half), out_valid <= 1.
- c5 and c6 together: c5 wins.
- Output latency: outbus and out_valid update one clock after the c5/c6 cycle. Both use the register values before that edge.
- When neither c5 nor c6 is asserted: out_valid <= 0 and outbus holds its last value.
- Product after WIDTH c2/c4 iterations = {A[WIDTH-1:0], Q}, signed 2*WIDTH bits.
- q_reg encoding: 01 means add, 10 means subtract, 00/11 mean no operation. The datapath does not check this; it obeys control as given.
- control = 0: every register holds.

Test Plan:
- Load M=3, Q=0xFE (-2) via c0/c1, then 8 Booth iterations (c2|c3 on q_reg=10, c2 on 01, c4 each iteration), then c5 and c6 -> outbus 0xFA then 0xFF, each with a one-cycle out_valid pulse one clock after its control cycle.
- 7 x 5 -> low 0x23, high 0x00.
- -128 x -128 -> low 0x00, high 0x40; checks the WIDTH+1 accumulator.
- Counter check -> counter_out=7 after 7 c4 pulses and 0 after the 8th (wrap); q_reg tracks {Q[0],Q_-1} each cycle.
- After c1 with M=3 and Q[0]=1, assert c2+c4 in one cycle -> A=1, Q[7]=1, Q_-1=1, counter=1.
- rst asserted mid-iteration (after 3 shifts) -> next cycle all registers 0, out_valid=0, counter_out=0. A fresh c0/c1 sequence then yields a correct product.
